// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_e;

  // Frame start marker
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // States in which the loader is willing to take a byte
  function automatic logic is_receiving(input loader_state_e s);
    return (s == IDLE) || (s == LEN_LO) || (s == LEN_HI) ||
           (s == DATA) || (s == CSUM);
  endfunction

  // States in which the inter-byte idle timeout is armed
  function automatic logic is_timed(input loader_state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================================
// Module      : prog_loader_if
// Description : Byte-stream input and instruction-memory write bus of the
//               program loader, plus the core-control status outputs.
//               slave  = loader side, master = byte source / memory side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_loader_if #(
  parameter int ADDRESS_WIDTH = 10
);

  logic                     byte_valid_i;
  logic [7:0]               byte_data_i;
  logic                     byte_ready_o;
  logic                     imem_wr_en_o;
  logic [ADDRESS_WIDTH-1:0] imem_wr_addr_o;
  logic [31:0]              imem_wr_data_o;
  logic                     core_rst_o;
  logic                     done_o;
  logic                     error_o;
  logic [15:0]              words_loaded_o;

  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output imem_wr_en_o,
    output imem_wr_addr_o,
    output imem_wr_data_o,
    output core_rst_o,
    output done_o,
    output error_o,
    output words_loaded_o
  );

  modport master (
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  imem_wr_en_o,
    input  imem_wr_addr_o,
    input  imem_wr_data_o,
    input  core_rst_o,
    input  done_o,
    input  error_o,
    input  words_loaded_o
  );

endinterface

`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
// ============================================================================
// Module      : word_packer
// Description : Assembles four consecutive bytes into a little-endian 32-bit
//               word. word_valid_o is combinational and coincides with the
//               4th byte so the caller can register the write one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;

  // Shift bytes in at the top so the first byte ends up in bits 7:0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lane  <= 2'd0;
      r_shift <= 24'd0;
    end else if (clear_i) begin
      r_lane  <= 2'd0;
      r_shift <= 24'd0;
    end else if (byte_valid_i) begin
      r_lane  <= r_lane + 2'd1;
      r_shift <= {byte_data_i, r_shift[23:8]};
    end
  end

  assign word_valid_o = byte_valid_i && (r_lane == 2'd3);
  assign word_o       = {byte_data_i, r_shift};

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Boot-time program loader. Parses a framed byte stream
//               (A5, length lo/hi, 4*N data bytes [, checksum]), writes the
//               little-endian words into instruction memory and keeps the
//               core in reset until the image is complete.
//               Optional checksum byte enabled by `LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  prog_loader_if.slave bus
);

  localparam int          c_idx_w    = ADDRESS_WIDTH - 2;
  localparam int unsigned c_capacity = 32'd1 << c_idx_w;
  localparam int          c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e c_after_data = CSUM;
`else
  localparam loader_state_e c_after_data = DONE;
`endif

  loader_state_e        r_state;
  loader_state_e        w_next_state;
  logic [7:0]           r_len_lo;
  logic [c_idx_w-1:0]   r_last_idx;
  logic [c_idx_w-1:0]   r_word_idx;
  logic [c_cnt_w-1:0]   r_idle_cnt;
  logic                 r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [31:0]          r_wr_data;
  logic [c_idx_w:0]     r_words_loaded;
  logic                 r_core_rst;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           r_csum;
`endif

  logic        w_ready;
  logic        w_accept;
  logic        w_timed;
  logic        w_expire;
  logic        w_frame_start;
  logic        w_data_byte;
  logic [15:0] w_len;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic        w_last_word;

  // Ready is forced low while reset is held, independent of the state value
  assign w_ready       = rst_ni && is_receiving(r_state);
  assign w_accept      = bus.byte_valid_i && w_ready;
  assign w_timed       = is_timed(r_state);
  assign w_expire      = w_timed && !w_accept &&
                         (r_idle_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
  assign w_frame_start = w_accept && (r_state == IDLE) && (bus.byte_data_i == SYNC_BYTE);
  assign w_data_byte   = w_accept && (r_state == DATA);
  assign w_len         = {bus.byte_data_i, r_len_lo};
  assign w_last_word   = w_word_valid && (r_word_idx == r_last_idx);

  word_packer u_word_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (w_frame_start),
    .byte_valid_i (w_data_byte),
    .byte_data_i  (bus.byte_data_i),
    .word_valid_o (w_word_valid),
    .word_o       (w_word)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Frame parser next-state logic; an idle expiry overrides everything
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_frame_start) w_next_state = LEN_LO;
      end
      LEN_LO: begin
        if (w_accept) w_next_state = LEN_HI;
      end
      LEN_HI: begin
        if (w_accept) begin
          if (w_len == 16'd0)                        w_next_state = c_after_data;
          else if (32'(w_len) > c_capacity)          w_next_state = ERROR;
          else                                       w_next_state = DATA;
        end
      end
      DATA: begin
        if (w_last_word) w_next_state = c_after_data;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_accept) w_next_state = (bus.byte_data_i == r_csum) ? DONE : ERROR;
      end
`endif
      DONE:    w_next_state = DONE;
      ERROR:   w_next_state = ERROR;
      default: w_next_state = ERROR;
    endcase
    if (w_expire) w_next_state = ERROR;
  end

  // Length capture: keep the low byte, then store N-1 as the last word index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len_lo   <= 8'd0;
      r_last_idx <= '0;
    end else if (w_accept && (r_state == LEN_LO)) begin
      r_len_lo <= bus.byte_data_i;
    end else if (w_accept && (r_state == LEN_HI)) begin
      r_last_idx <= w_len[c_idx_w-1:0] - c_idx_w'(1);
    end
  end

  // Idle counter only runs inside a frame and clears on every accepted byte
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle_cnt <= '0;
    end else if (!w_timed || w_accept) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + c_cnt_w'(1);
    end
  end

  // Memory write port, registered one cycle after the 4th byte of a word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= 32'd0;
      r_word_idx     <= '0;
      r_words_loaded <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_frame_start) begin
        r_word_idx <= '0;
      end else if (w_word_valid) begin
        r_wr_en        <= 1'b1;
        r_wr_addr      <= {r_word_idx, 2'b00};
        r_wr_data      <= w_word;
        r_word_idx     <= r_word_idx + c_idx_w'(1);
        r_words_loaded <= r_words_loaded + (c_idx_w + 1)'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every data byte in the current frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_csum <= 8'd0;
    end else if (w_frame_start) begin
      r_csum <= 8'd0;
    end else if (w_data_byte) begin
      r_csum <= r_csum ^ bus.byte_data_i;
    end
  end
`endif

  // Core reset drops one cycle after DONE so the final write lands first
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_core_rst <= 1'b1;
    end else begin
      r_core_rst <= (r_state != DONE);
    end
  end

  assign bus.byte_ready_o   = w_ready;
  assign bus.imem_wr_en_o   = r_wr_en;
  assign bus.imem_wr_addr_o = r_wr_addr;
  assign bus.imem_wr_data_o = r_wr_data;
  assign bus.core_rst_o     = r_core_rst;
  assign bus.done_o         = (r_state == DONE);
  assign bus.error_o        = (r_state == ERROR);
  assign bus.words_loaded_o = 16'(r_words_loaded);

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A byte-level frame
//               parser model predicts every output on every cycle; literal
//               expectations pin the model on the directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  localparam int AW  = 10;
  localparam int TO  = 40;
  localparam int CAP = 256;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDRESS_WIDTH(AW)) bus ();

  prog_loader #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] tx_words[$];

  // Model: byte position inside a frame, result 0=running 1=done 2=error
  int          m_result, m_pos, m_n, m_idle, m_words, m_done_age;
  bit          m_in_frame, m_wr_pend, m_acc;
  logic [31:0] m_wr_addr, m_wr_data;
  logic [7:0]  m_bytes[$];
  logic [7:0]  m_xor;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_result = 0; m_pos = 0; m_n = 0; m_idle = 0; m_words = 0; m_done_age = 0;
    m_in_frame = 0; m_wr_pend = 0; m_wr_addr = 0; m_wr_data = 0; m_xor = 0;
    m_bytes.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int i;
    if (m_pos == 0) begin
      m_n = int'(b);
    end else if (m_pos == 1) begin
      m_n = m_n + 256 * int'(b);
      if (m_n > CAP) m_result = 2;
      else if (m_n == 0 && !CSUM_EN) m_result = 1;
    end else if (m_pos < 2 + 4 * m_n) begin
      i = m_pos - 2;
      m_bytes.push_back(b);
      m_xor = m_xor ^ b;
      if (i % 4 == 3) begin
        m_wr_pend = 1;
        m_wr_addr = 32'((i / 4) * 4);
        m_wr_data = {m_bytes[i], m_bytes[i-1], m_bytes[i-2], m_bytes[i-3]};
        m_words++;
        if (i == 4 * m_n - 1 && !CSUM_EN) m_result = 1;
      end
    end else begin
      m_result = (b == m_xor) ? 1 : 2;
    end
    m_pos++;
  endtask

  // Compare every output each cycle, then advance the model by this cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_wr_en", 32'(bus.imem_wr_en_o), 0);
      check("rst_addr", 32'(bus.imem_wr_addr_o), 0);
      check("rst_data", bus.imem_wr_data_o, 0);
      check("rst_core_rst", 32'(bus.core_rst_o), 1);
      check("rst_done", 32'(bus.done_o), 0);
      check("rst_error", 32'(bus.error_o), 0);
      check("rst_ready", 32'(bus.byte_ready_o), 0);
      check("rst_words", 32'(bus.words_loaded_o), 0);
      model_reset();
    end else begin
      check("ready", 32'(bus.byte_ready_o), 32'(m_result == 0));
      check("wr_en", 32'(bus.imem_wr_en_o), 32'(m_wr_pend));
      if (m_wr_pend) begin
        check("wr_addr", 32'(bus.imem_wr_addr_o), m_wr_addr);
        check("wr_data", bus.imem_wr_data_o, m_wr_data);
      end
      check("words_loaded", 32'(bus.words_loaded_o), 32'(m_words));
      check("done", 32'(bus.done_o), 32'(m_result == 1));
      check("error", 32'(bus.error_o), 32'(m_result == 2));
      check("core_rst", 32'(bus.core_rst_o), 32'(!(m_result == 1 && m_done_age >= 1)));
      if (bus.imem_wr_en_o) begin
        log_addr.push_back(32'(bus.imem_wr_addr_o));
        log_data.push_back(bus.imem_wr_data_o);
      end
      m_acc = bus.byte_valid_i && (m_result == 0);
      m_wr_pend = 0;
      if (m_result == 1) m_done_age++;
      if (m_result == 0) begin
        if (!m_in_frame) begin
          if (m_acc && bus.byte_data_i == 8'hA5) begin
            m_in_frame = 1; m_pos = 0; m_idle = 0; m_xor = 0; m_bytes.delete();
          end
        end else if (m_acc) begin
          m_idle = 0;
          model_byte(bus.byte_data_i);
        end else begin
          m_idle++;
          if (m_idle >= TO) m_result = 2;
        end
      end
    end
  end

  function automatic int rgap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  // Hold valid low for gap cycles, then present b until it is taken
  task automatic send(input logic [7:0] b, input int gap);
    int waited;
    bus.byte_valid_i = 1'b0;
    repeat (gap) begin
      bus.byte_data_i = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.byte_ready_o) break;
      waited++;
      if (waited > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_stall: byte %0h not accepted after %0d cycles", b, waited);
        bus.byte_valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int max_gap, input bit bad_csum);
    logic [7:0] x;
    logic [7:0] b;
    int n;
    x = 8'd0;
    n = tx_words.size();
    send(8'hA5, rgap(max_gap));
    send(n[7:0], rgap(max_gap));
    send(n[15:8], rgap(max_gap));
    foreach (tx_words[w]) begin
      for (int k = 0; k < 4; k++) begin
        b = tx_words[w][8*k +: 8];
        x = x ^ b;
        send(b, rgap(max_gap));
      end
    end
    if (CSUM_EN) send(bad_csum ? (x ^ 8'h01) : x, rgap(max_gap));
  endtask

  task automatic idle(input int n);
    bus.byte_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.byte_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    log_addr.delete();
    log_data.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_log_vs_tx(input string tag);
    check({tag, "_count"}, 32'(log_data.size()), 32'(tx_words.size()));
    foreach (tx_words[i]) begin
      check({tag, "_addr"}, log_addr[i], 32'(i * 4));
      check({tag, "_data"}, log_data[i], tx_words[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'd0;
    do_reset();

    // No timeout applies before a frame starts
    idle(2 * TO);
    check("idle_error", 32'(bus.error_o), 0);
    check("idle_ready", 32'(bus.byte_ready_o), 1);

    // Two-word reference frame
    tx_words = '{32'h00000013, 32'h00100093};
    send_frame(0, 1'b0);
    idle(4);
    check("t1_count", 32'(log_data.size()), 2);
    check("t1_addr0", log_addr[0], 32'h0);
    check("t1_data0", log_data[0], 32'h00000013);
    check("t1_addr1", log_addr[1], 32'h4);
    check("t1_data1", log_data[1], 32'h00100093);
    check("t1_words", 32'(bus.words_loaded_o), 2);
    check("t1_done", 32'(bus.done_o), 1);
    check("t1_core_rst", 32'(bus.core_rst_o), 0);
    check("t1_model_words", 32'(m_words), 2);

    // Garbage before sync, then an empty image
    do_reset();
    send(8'h00, 0); send(8'hFF, 0);
    tx_words.delete();
    send_frame(0, 1'b0);
    idle(4);
    check("t2_done", 32'(bus.done_o), 1);
    check("t2_nowrite", 32'(log_data.size()), 0);
    check("t2_model_result", 32'(m_result), 1);

    // Oversized length
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0);
    idle(3);
    check("t3_error", 32'(bus.error_o), 1);
    check("t3_core_rst", 32'(bus.core_rst_o), 1);
    check("t3_ready", 32'(bus.byte_ready_o), 0);

    // Silence mid-word, then recovery after reset
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h11, 0); send(8'h22, 0);
    idle(TO + 5);
    check("t4_error", 32'(bus.error_o), 1);
    check("t4_nowrite", 32'(log_data.size()), 0);
    do_reset();
    tx_words = '{32'h00000013, 32'h00100093};
    send_frame(3, 1'b0);
    idle(4);
    check_log_vs_tx("t4_recover");
    check("t4_done", 32'(bus.done_o), 1);

    // Byte arriving on the last allowed idle cycle is taken
    do_reset();
    send(8'hA5, 0);
    send(8'h01, TO - 1); send(8'h00, TO - 1);
    send(8'h13, TO - 1); send(8'h00, 0); send(8'h00, 0); send(8'h00, TO - 1);
    if (CSUM_EN) send(8'h13, TO - 1);
    idle(4);
    check("t5_done", 32'(bus.done_o), 1);
    check("t5_data", log_data[0], 32'h00000013);

    // Reset in the middle of a word leaves nothing behind
    do_reset();
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_nowrite", 32'(log_data.size()), 0);
    rst_n = 1'b1;
    tx_words = '{32'h00000013, 32'h00100093};
    send_frame(1, 1'b0);
    idle(4);
    check_log_vs_tx("t6_after");

    // Full-capacity image
    do_reset();
    tx_words.delete();
    for (int i = 0; i < CAP; i++) tx_words.push_back($urandom);
    send_frame(1, 1'b0);
    idle(4);
    check_log_vs_tx("t7_cap");
    check("t7_last_addr", log_addr[CAP-1], 32'd1020);
    check("t7_words", 32'(bus.words_loaded_o), 32'd256);
    check("t7_done", 32'(bus.done_o), 1);

    // Random short frames with random valid gaps
    for (int f = 0; f < 4; f++) begin
      do_reset();
      tx_words.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) tx_words.push_back($urandom);
      send_frame(3, 1'b0);
      idle(4);
      check_log_vs_tx("t8_rand");
      check("t8_done", 32'(bus.done_o), 1);
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    tx_words = '{32'h00000013};
    send_frame(0, 1'b0);
    idle(4);
    check("t9_good_done", 32'(bus.done_o), 1);
    do_reset();
    send_frame(0, 1'b1);
    idle(4);
    check("t9_bad_error", 32'(bus.error_o), 1);
    check("t9_bad_written", 32'(log_data.size()), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader upstream of the single-cycle core.
- Receives a framed byte stream (from a UART receiver) and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory write port.
- Holds the core in reset until the image is fully loaded, then releases it.

Parameters:
AddressWidth, 10, byte-address width of instruction memory; capacity is 2^(AddressWidth-2) words
TimeoutCycles, 100000, maximum idle cycles between accepted bytes once a frame has started

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
byte_valid_i  input  1  incoming byte valid
byte_data_i  input  8  incoming byte
byte_ready_o  output  1  loader can accept a byte
imem_wr_en_o  output  1  one-cycle instruction memory write strobe
imem_wr_addr_o  output  AddressWidth  byte address of the word being written, word aligned
imem_wr_data_o  output  32  instruction word
core_rst_o  output  1  active-high reset to the core datapath
done_o  output  1  load complete
error_o  output  1  load failed
words_loaded_o  output  16  count of words written

Behaviour:
- Reset:
  - The interface is one clock; reset is asynchronous and active-low (clk_i, rst_ni).
  - Reset values: state IDLE, all counters 0, imem_wr_en_o 0, imem_wr_addr_o 0, imem_wr_data_o 0, core_rst_o 1, done_o 0, error_o 0, byte_ready_o 0 during reset.
  - Asserting rst_ni mid-load aborts the frame. No partial word is written.
- Handshake:
  - A byte is accepted on any cycle with byte_valid_i & byte_ready_o.
  - byte_ready_o is 1 in IDLE, LEN_LO, LEN_HI, DATA and CSUM, and 0 in DONE and ERROR.
- State machine:
  - IDLE: an accepted byte 8'hA5 moves to LEN_LO. Any other byte is discarded and the state stays IDLE.
  - LEN_LO, LEN_HI: capture word count N, low byte first.
    - N == 0 goes to DONE.
    - N > 2^(AddressWidth-2) goes to ERROR.
    - Otherwise go to DATA.
  - DATA: bytes are packed little-endian (first byte to bits 7:0).
    - On the 4th byte of a word, the next cycle has imem_wr_en_o = 1 for exactly one cycle, with imem_wr_addr_o = word_index*4 and imem_wr_data_o = the assembled word. Latency is 1 cycle.
    - words_loaded_o increments in that same cycle.
    - After the Nth word: go to CSUM if the feature is enabled, else go to DONE.
  - DONE: terminal. done_o = 1. core_rst_o falls one cycle after DONE is entered, so the final write always completes before the core runs.
  - ERROR: terminal until rst_ni. error_o = 1 and core_rst_o stays 1.
- Timeout:
  - Applies in LEN_LO, LEN_HI, DATA and CSUM.
  - An idle counter clears on each accepted byte and increments otherwise.
  - When it reaches TimeoutCycles, go to ERROR. No timeout applies in IDLE.
- Boundary conditions:
  - A full-capacity image (N = 2^(AddressWidth-2)) loads successfully. The last address written is 2^AddressWidth-4; the address never wraps.
  - A byte arriving in the same cycle the timeout expires is accepted, and the timeout is cancelled.
  - The word index is AddressWidth-2 bits wide. words_loaded_o is zero-extended to 16 bits.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of all DATA bytes is kept.
  - After the Nth word, one extra byte is expected in state CSUM. Match goes to DONE; mismatch goes to ERROR.
  - Words already written stay in memory.
  - With N == 0, the CSUM byte is still required and must be 8'h00.
- When not defined: the CSUM state, the XOR register and the extra byte do not exist.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR);
  - localparam SYNC_BYTE = 8'hA5.
- One sub-module, word_packer:
  - 2-bit byte lane counter plus 32-bit shift/assemble register;
  - pulses word_valid when the 4th byte lands;
  - has a clear input used on frame start.

Test Plan:
- Reset then the stream A5 02 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 at addr 0 and 0x00100093 at addr 4. words_loaded_o = 2, done_o = 1, core_rst_o falls 1 cycle after DONE.
- Bytes 00 FF before A5, then A5 00 00 -> garbage ignored, N = 0, goes to DONE, no imem writes.
- A5 01 01 (N = 257, AddressWidth = 10) -> error_o = 1, core_rst_o stays 1, byte_ready_o = 0.
- A5 01 00 11 22 then silence for TimeoutCycles -> ERROR, no write. Then reset and a valid frame loads correctly.
- byte_valid_i toggled randomly with the 2-word frame -> identical writes, each exactly one cycle wide.
- LOADER_CHECKSUM_EN defined:
  - frame 1 word 0x00000013 followed by 13 -> DONE;
  - the same frame followed by 12 -> word written, then ERROR.
